// File: rtl/dvp_tx.sv
// dvp_tx: DVP camera-style transmitter.
// Turns a 16-bit RGB565 pixel stream into vsync/href/8-bit byte timing,
// high byte first, one frame per start pulse. Used as an on-chip camera
// emulator for loopback and self-test of the capture path.
//
// Optional build macro DVP_TX_TEST_PATTERN_EN adds a test_mode input. A frame
// started with test_mode=1 sends a built-in row/col pattern instead of
// consuming the stream.
module dvp_tx #(
  parameter int WIDTH     = 24,
  parameter int HEIGHT    = 16,
  parameter int VSYNC_LEN = 20,
  parameter int VBP       = 40,
  parameter int HBLANK    = 20,
  parameter int VFP       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
`ifdef DVP_TX_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        pix_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam int T_MAX_A = (VSYNC_LEN > VBP) ? VSYNC_LEN : VBP;
  localparam int T_MAX_B = (HBLANK > VFP) ? HBLANK : VFP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TMR_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TMR_W-1:0] VS_LAST  = TMR_W'(VSYNC_LEN - 1);
  localparam logic [TMR_W-1:0] VBP_LAST = TMR_W'(VBP - 1);
  localparam logic [TMR_W-1:0] HB_LAST  = TMR_W'(HBLANK - 1);
  localparam logic [TMR_W-1:0] VFP_LAST = TMR_W'(VFP - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  // Every phase needs at least one cycle, otherwise the timer compares break.
  if (VSYNC_LEN < 1 || VBP < 1 || HBLANK < 1 || VFP < 1 || WIDTH < 1 || HEIGHT < 1) begin : g_param_check
    $error("dvp_tx: all geometry and phase parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VSYNC   = 3'd1,
    VBP_S   = 3'd2,
    LINE_HI = 3'd3,
    LINE_LO = 3'd4,
    HBLANK_S = 3'd5,
    VFP_S   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [15:0]      pix_q, pix_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             vsync_q, vsync_d;
  logic             href_q, href_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic [15:0]      srcPix;
  logic             patternMode;

`ifdef DVP_TX_TEST_PATTERN_EN
  logic             pattern_q, pattern_d;
  logic [15:0]      patPix;

  // Built-in pattern for the pixel about to be sent: (row%8)*10 + (col%8).
  always_comb begin
    patPix = ((16'(row_d) & 16'd7) * 16'd10) + (16'(col_d) & 16'd7);
  end

  assign patternMode = pattern_q;
`else
  assign patternMode = 1'b0;
`endif

  // Pixel that enters the byte pipeline on a LINE_HI entry; a missing stream pixel is sent as zero.
  always_comb begin
    srcPix = pix_valid ? pix_data : 16'h0000;
`ifdef DVP_TX_TEST_PATTERN_EN
    if (pattern_q) begin
      srcPix = patPix;
    end
`endif
  end

  // Next-state, counter and look-ahead output logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    col_d      = col_q;
    row_d      = row_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = underrun_q | (ready_q & ~pix_valid);
`ifdef DVP_TX_TEST_PATTERN_EN
    pattern_d  = pattern_q;
`endif

    case (state_q)
      IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start) begin
          state_d    = VSYNC;
          busy_d     = 1'b1;
          underrun_d = 1'b0;
          timer_d    = '0;
          col_d      = '0;
          row_d      = '0;
`ifdef DVP_TX_TEST_PATTERN_EN
          pattern_d  = test_mode;
`endif
        end
      end
      VSYNC: begin
        if (timer_q == VS_LAST) begin
          state_d = VBP_S;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      VBP_S: begin
        if (timer_q == VBP_LAST) begin
          state_d = LINE_HI;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      LINE_HI: begin
        state_d = LINE_LO;
      end
      LINE_LO: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          timer_d = '0;
          state_d = (row_q == ROW_LAST) ? VFP_S : HBLANK_S;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = LINE_HI;
        end
      end
      HBLANK_S: begin
        if (timer_q == HB_LAST) begin
          state_d = LINE_HI;
          timer_d = '0;
          row_d   = row_q + ROW_W'(1);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      VFP_S: begin
        if (timer_q == VFP_LAST) begin
          state_d = IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    vsync_d = (state_d == VSYNC);
    href_d  = (state_d == LINE_HI) || (state_d == LINE_LO);

    pix_d  = pix_q;
    data_d = 8'h00;
    if (state_d == LINE_HI) begin
      pix_d  = srcPix;
      data_d = srcPix[15:8];
    end else if (state_d == LINE_LO) begin
      data_d = pix_q[7:0];
    end

    ready_d = ~patternMode &
              (((state_d == VBP_S)    && (timer_d == VBP_LAST)) ||
               ((state_d == HBLANK_S) && (timer_d == HB_LAST))  ||
               ((state_d == LINE_LO)  && (col_d != COL_LAST)));
  end

  // State, counters and all registered outputs; async reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      pix_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
`ifdef DVP_TX_TEST_PATTERN_EN
      pattern_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pix_q      <= pix_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
`ifdef DVP_TX_TEST_PATTERN_EN
      pattern_q  <= pattern_d;
`endif
    end
  end

  assign pix_ready  = ready_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = underrun_q;

endmodule
